// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built around one full-adder slice.
// Each operation processes one bit per clock, starting at the LSB, and takes
// WIDTH cycles in RUN. The result registers update together on the completion
// edge and hold their value until the next completion.
//
// Ports
//   i_clk    clock, rising edge active
//   i_rst_n  asynchronous active-low reset
//   i_start  start request, accepted in IDLE or DONE only
//   i_a/i_b  operands, captured on the accepting edge
//   i_cin    carry-in (add mode only)
//   i_sub    0: A+B+cin, 1: A-B (A + ~B + 1)
//   o_sum    result of the last completed operation
//   o_carry  carry out of the MSB (subtract: 1 = no borrow)
//   o_ovf    signed overflow of the last result
//   o_busy   high while the operation is in progress
//   o_done   one-cycle completion pulse
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_busy,
  output logic             o_done
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bit_s;
  logic             bit_c;
  logic             last;
  logic [WIDTH-1:0] acc_next;

  // Full-adder slice on the current LSBs of the operand shift registers.
  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Result bits enter at the MSB and move right, so after WIDTH shifts bit 0
  // sits in position 0. Written with shifts so that WIDTH=1 needs no slicing.
  assign acc_next = (acc_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_next;
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = acc_next;
          cout_d  = bit_c;
          // carry_q is the carry into the MSB at this point.
          ovf_d   = carry_q ^ bit_c;
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation.
        state_d = S_IDLE;
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_sub ? ~i_b : i_b;
          acc_d   = '0;
          carry_d = i_sub ? 1'b1 : i_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = cout_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = (state_q == S_RUN);
  assign o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 table vectors and corner sequences,
// plus random sweeps on WIDTH=1 and WIDTH=32 instances against a model.
module tb_serial_adder;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // WIDTH=8 instance
  logic       start8, cin8, sub8, carry8, ovf8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       start1, cin1, sub1, carry1, ovf1, busy1, done1;
  logic [0:0] a1, b1, sum1;
  // WIDTH=32 instance
  logic        start32, cin32, sub32, carry32, ovf32, busy32, done32;
  logic [31:0] a32, b32, sum32;

  exp_t q8[$];
  exp_t q1[$];
  exp_t q32[$];
  logic [7:0] last8 = 8'h00;

  serial_adder #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
    .i_cin(cin8), .i_sub(sub8), .o_sum(sum8), .o_carry(carry8), .o_ovf(ovf8),
    .o_busy(busy8), .o_done(done8));

  serial_adder #(.WIDTH(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1),
    .i_cin(cin1), .i_sub(sub1), .o_sum(sum1), .o_carry(carry1), .o_ovf(ovf1),
    .o_busy(busy1), .o_done(done1));

  serial_adder #(.WIDTH(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_a(a32), .i_b(b32),
    .i_cin(cin32), .i_sub(sub32), .o_sum(sum32), .o_carry(carry32), .o_ovf(ovf32),
    .o_busy(busy32), .o_done(done32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result sign bits.
  function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin, input logic sub);
    logic [63:0] mask, bb, aa, full;
    exp_t e;
    mask    = (64'd1 << w) - 64'd1;
    aa      = a & mask;
    bb      = sub ? (~b & mask) : (b & mask);
    full    = aa + bb + 64'(sub ? 1'b1 : cin);
    e.sum   = full & mask;
    e.carry = full[w];
    e.ovf   = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    e.due   = 0;
    return e;
  endfunction

  // Scoreboard monitors: pop on every done pulse.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("spurious_done8", 64'(done8), 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", 64'(sum8), e.sum);
        chk("carry8", 64'(carry8), 64'(e.carry));
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
        chk("latency8", 64'(cyc), 64'(e.due));
        last8 = e.sum[7:0];
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 64'(done1), 64'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("sum1", 64'(sum1), e.sum);
        chk("carry1", 64'(carry1), 64'(e.carry));
        chk("ovf1", 64'(ovf1), 64'(e.ovf));
        chk("latency1", 64'(cyc), 64'(e.due));
      end
    end
    if (done32) begin
      if (q32.size() == 0) chk("spurious_done32", 64'(done32), 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        chk("sum32", 64'(sum32), e.sum);
        chk("carry32", 64'(carry32), 64'(e.carry));
        chk("ovf32", 64'(ovf32), 64'(e.ovf));
        chk("latency32", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic scramble8();
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    cin8 = 1'($urandom_range(0, 1));
    sub8 = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge; the following rising edge accepts the operation.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    e.sum = 64'(es); e.carry = ec; e.ovf = eo; e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    scramble8();
  endtask

  // Waits for done; operands are scrambled and the held result checked each RUN cycle.
  task automatic wait8(output int unsigned nb);
    int unsigned n;
    n  = 0;
    nb = 0;
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      chk("hold8", 64'(sum8), 64'(last8));
      scramble8();
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout8", 64'(done8), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int unsigned nb;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    #1;
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_carry", 64'(carry8), 64'd0);
    chk("rst_ovf", 64'(ovf8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, one at a time with an idle cycle after each.
    for (int i = 0; i < 8; i++) begin
      go8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sum, tbl[i].carry, tbl[i].ovf);
      wait8(nb);
      chk("busy_cycles8", 64'(nb), 64'd8);
      @(negedge clk);
      chk("done_width8", 64'(done8), 64'd0);
    end

    // Back-to-back: second start lands in the DONE cycle.
    go8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    wait8(nb);
    go8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    wait8(nb);
    chk("b2b_busy8", 64'(nb), 64'd8);
    @(negedge clk);

    // Start pulse during RUN cycle 3 must be ignored.
    go8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA;
    @(negedge clk);
    start8 = 1'b0;
    chk("ignore_busy8", 64'(busy8), 64'd1);
    wait8(nb);
    repeat (12) @(negedge clk);
    chk("hold_idle8", 64'(sum8), 64'h30);

    // Reset asserted between edges during RUN cycle 4.
    go8(8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q8.delete();
    last8 = 8'h00;
    chk("midrst_sum", 64'(sum8), 64'd0);
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_sum", 64'(sum8), 64'd0);
    go8(8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);
    wait8(nb);
    chk("postrst_busy8", 64'(nb), 64'd8);
    @(negedge clk);

    // Random sweeps on the WIDTH=1 and WIDTH=32 instances.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [63:0] ra, rb;
          logic rc, rs;
          exp_t e;
          int unsigned n;
          ra = 64'($urandom); rb = 64'($urandom);
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          e = model(1, ra, rb, rc, rs);
          e.due = cyc + 1 + 1;
          q1.push_back(e);
          a1 = ra[0:0]; b1 = rb[0:0]; cin1 = rc; sub1 = rs; start1 = 1'b1;
          @(negedge clk);
          start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1; sub1 = ~sub1;
          n = 0;
          while (!done1 && n < 10) begin @(negedge clk); n++; end
          if (!done1) chk("timeout1", 64'(done1), 64'd1);
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          logic [63:0] ra, rb;
          logic rc, rs;
          exp_t e;
          int unsigned n, nb32;
          ra = 64'($urandom); rb = 64'($urandom);
          if (i == 0) begin ra = 64'hFFFF_FFFF; rb = 64'h1; end
          if (i == 1) begin ra = 64'h7FFF_FFFF; rb = 64'h1; end
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          if (i < 2) begin rc = 1'b0; rs = 1'b0; end
          e = model(32, ra, rb, rc, rs);
          e.due = cyc + 1 + 32;
          q32.push_back(e);
          a32 = ra[31:0]; b32 = rb[31:0]; cin32 = rc; sub32 = rs; start32 = 1'b1;
          @(negedge clk);
          start32 = 1'b0; a32 = ~a32; b32 = 32'($urandom); cin32 = ~cin32; sub32 = ~sub32;
          n = 0;
          nb32 = 0;
          while (!done32 && n < 50) begin
            if (busy32) nb32++;
            @(negedge clk);
            n++;
          end
          if (!done32) chk("timeout32", 64'(done32), 64'd1);
          else chk("busy_cycles32", 64'(nb32), 64'd32);
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      end
    join

    repeat (3) @(negedge clk);
    chk("sb8_drained", 64'(q8.size()), 64'd0);
    chk("sb1_drained", 64'(q1.size()), 64'd0);
    chk("sb32_drained", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 Port: i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE state.
REQ-005 Port: i_a  input  WIDTH  operand A; sampled on accepting edge only.
REQ-006 Port: i_b  input  WIDTH  operand B; sampled on accepting edge only.
REQ-007 Port: i_cin  input  1  carry-in, add mode only; sampled on accepting edge.
REQ-008 Port: i_sub  input  1  mode; 0 = A+B+cin, 1 = A-B (A + ~B + 1, i_cin ignored); sampled on accepting edge.
REQ-009 Port: o_sum  output  WIDTH  registered result of last completed operation.
REQ-010 Port: o_carry  output  1  carry out of MSB of last result (sub mode: 1 = no borrow).
REQ-011 Port: o_ovf  output  1  signed overflow of last result.
REQ-012 Port: o_busy  output  1  high while state is RUN.
REQ-013 Port: o_done  output  1  one-cycle completion pulse, high while state is DONE.

Function
REQ-014 Datapath SHALL be a single 1-bit full-adder slice (sum = a^b^c, carry = majority(a,b,c)) plus a carry register, processing one bit per clock, LSB first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: i_start=1 -> load A and B (B inverted if i_sub) into shift registers, carry reg <= (i_sub ? 1 : i_cin), bit counter <= 0, go RUN; else stay IDLE.
REQ-017 RUN: each edge shifts one result bit into sum shift register, updates carry reg, increments counter; when counter reaches WIDTH-1, that edge SHALL complete the operation and go DONE.
REQ-018 Completion edge SHALL load o_sum, o_carry (final carry), o_ovf (carry into MSB XOR carry out of MSB) simultaneously.
REQ-019 Latency: exactly WIDTH rising edges from accepting edge to completion edge; o_done high for exactly the following cycle.
REQ-020 DONE: lasts one cycle; i_start=1 -> accept new operation as in REQ-016 and go RUN (back-to-back); else go IDLE.
REQ-021 i_start while RUN SHALL be ignored; operands, mode and in-flight computation unaffected.
REQ-022 o_sum, o_carry, o_ovf SHALL hold their value from the completion edge until the next completion edge; they do not change during RUN.
REQ-023 Changes on i_a, i_b, i_cin, i_sub outside accepting edge SHALL have no effect.
REQ-024 WIDTH=1: single RUN cycle; o_ovf = cin XOR cout of bit 0.
REQ-025 Bit counter width SHALL be $clog2(WIDTH)+1 bits minimum; no wrap before WIDTH-1 for any legal WIDTH.

Reset
REQ-026 i_rst_n=0 SHALL immediately, independent of i_clk, force state IDLE, o_sum=0, o_carry=0, o_ovf=0, o_busy=0, o_done=0, counter=0, carry reg=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no o_done pulse; outputs become reset values.
REQ-028 First accepting edge is the first rising edge with i_rst_n=1 and i_start=1.

Verification (WIDTH=8 unless noted)
REQ-029 Add: A=8'h0F, B=8'h01, cin=0, sub=0 -> o_busy 8 cycles, o_done 1 cycle, o_sum=8'h10, o_carry=0, o_ovf=0.
REQ-030 Carry/overflow: A=8'hFF+B=8'h01, cin=0 -> o_sum=8'h00, o_carry=1, o_ovf=0; then A=8'h7F+B=8'h01 back-to-back in DONE cycle -> o_sum=8'h80, o_carry=0, o_ovf=1, 8 cycles later.
REQ-031 Subtract: A=8'h05, B=8'h07, sub=1, cin=1 (ignored) -> o_sum=8'hFE, o_carry=0, o_ovf=0.
REQ-032 Busy ignore: start A=8'h10+B=8'h20; pulse i_start with A=8'hAA on RUN cycle 3 -> single o_done, o_sum=8'h30; prior o_sum unchanged during RUN.
REQ-033 Reset mid-op: start A=8'h55+B=8'h55, assert i_rst_n=0 on RUN cycle 4 between edges -> outputs 0 immediately, no o_done; next op correct.
REQ-034 Parameter sweep: WIDTH=1 and WIDTH=32, random operands/modes vs. reference model A+B+cin / A-B, checking sum, carry, ovf and latency WIDTH.
